axi_arb_bridge: RTL and testbench
=================================

AXI_ARB_BRIDGE -- requirements
Module: axi_arb_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 32 and 64.
REQ-003 SHALL have parameter IFU_ID, default 4'd0, AXI ID for fetch transactions.
REQ-004 SHALL have parameter LSU_ID, default 4'd1, AXI ID for load/store transactions.
REQ-005 SHALL have clock, input, 1, sole clock, rising edge.
REQ-006 SHALL have reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ifu_req_valid/ifu_req_ready, input/output, 1 each, fetch request handshake.
REQ-008 SHALL have ifu_addr, input, ADDR_W, fetch address.
REQ-009 SHALL have ifu_rsp_valid, output, 1, one-cycle fetch completion pulse.
REQ-010 SHALL have ifu_rdata and ifu_rsp_err, output, DATA_W and 1, fetch data and error flag.
REQ-011 SHALL have lsu_req_valid/lsu_req_ready, input/output, 1 each, load/store request handshake.
REQ-012 SHALL have lsu_we, lsu_addr, lsu_wdata, lsu_wstrb, lsu_size, inputs, 1/ADDR_W/DATA_W/DATA_W/8/3, store select, address, data, byte strobe, AXI size code.
REQ-013 SHALL have lsu_rsp_valid, lsu_rdata, lsu_rsp_err, outputs, 1/DATA_W/1, completion pulse, load data, error flag.
REQ-014 SHALL have io_master AW group: awvalid out, awready in, awaddr out ADDR_W, awid out 4, awlen out 8, awsize out 3, awburst out 2.
REQ-015 SHALL have io_master W group: wvalid out, wready in, wdata out DATA_W, wstrb out DATA_W/8, wlast out.
REQ-016 SHALL have io_master B group: bvalid in, bready out, bresp in 2, bid in 4.
REQ-017 SHALL have io_master AR group: arvalid out, arready in, araddr out ADDR_W, arid out 4, arlen out 8, arsize out 3, arburst out 2.
REQ-018 SHALL have io_master R group: rvalid in, rready out, rdata in DATA_W, rresp in 2, rlast in, rid in 4.

Function
REQ-019 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; exactly one AXI transaction outstanding.
REQ-020 SHALL assert ifu_req_ready and lsu_req_ready only in IDLE and only to the granted requester; grant = valid&ready same cycle.
REQ-021 SHALL arbitrate round-robin on a 1-bit last-grant register when both request in IDLE; single requester always wins; after reset LSU has priority.
REQ-022 SHALL latch address, ID, size, wdata, wstrb on grant; AXI outputs SHALL remain stable while valid is high.
REQ-023 SHALL go IDLE->RD_ADDR on fetch or load grant, IDLE->WR_REQ on store grant.
REQ-024 SHALL in RD_ADDR drive arvalid=1, arlen=0, arburst=2'b01; arsize = log2(DATA_W/8) for fetch, lsu_size for load; arvalid&arready -> RD_DATA.
REQ-025 SHALL in RD_DATA drive rready=1; rvalid -> pulse the granted client's rsp_valid next cycle with registered rdata, return to IDLE.
REQ-026 SHALL in WR_REQ assert awvalid and wvalid together with wlast=1; track AW and W completion independently; leave when both done (same or different cycles) -> WR_RESP.
REQ-027 SHALL in WR_RESP drive bready=1; bvalid -> pulse lsu_rsp_valid next cycle with lsu_rdata=0, return to IDLE.
REQ-028 SHALL set rsp_err=1 when rresp/bresp != 2'b00, rid/bid != issued ID, or rlast=0 on the read beat; transaction still completes.
REQ-029 SHALL keep rsp_valid pulses exactly one cycle; clients accept unconditionally.
REQ-030 SHALL deassert all valid/ready outputs in IDLE; awburst=2'b01, awlen=0 constant.
REQ-031 SHALL ignore rvalid/bvalid outside RD_DATA/WR_RESP.
REQ-032 SHALL reach minimum fetch latency of 3 cycles from grant to ifu_rsp_valid with zero-wait slave.

Reset
REQ-033 SHALL on reset low immediately force IDLE, all valid/ready/rsp outputs 0, data outputs 0, last-grant to favour LSU.
REQ-034 SHALL abandon any in-flight transaction on reset mid-operation with no response pulse; the slave is reset concurrently.

Verification
REQ-035 Fetch 0x8000_0000, zero-wait slave, rdata 0x0000_0413 -> arid=IFU_ID, ifu_rsp_valid one cycle with rdata 0x0000_0413, err=0.
REQ-036 Both request continuously -> grants alternate LSU, IFU, LSU, IFU.
REQ-037 Store 0xDEADBEEF strb 4'b0011, awready 3 cycles after wready -> single AW and W beats, wlast=1, one lsu_rsp_valid after bvalid.
REQ-038 Load with rresp=2'b10 -> lsu_rsp_err=1, FSM returns IDLE.
REQ-039 Read with rid != arid -> rsp_err=1.
REQ-040 Reset low during RD_DATA -> outputs 0 asynchronously, no rsp pulse, next fetch after release completes normally.

Source files
------------

// File: rtl/axi_arb_bridge.sv
// rtl/axi_arb_bridge.sv - round-robin fetch/load-store arbiter onto a single-outstanding AXI master
//
// Purpose:
//   Two clients (IFU fetch, LSU load/store) share one AXI master port. One
//   transaction is in flight at a time. Each transaction is a single beat
//   (len 0, INCR). Responses come back to the owning client as a one-cycle
//   registered pulse carrying data and an error flag.
//
// Ports:
//   clk, rst_n          - sole clock (rising edge), asynchronous active-low reset
//   ifu_req_*           - fetch request handshake and address
//   ifu_rsp_*, ifu_rdata - fetch completion pulse, data, error
//   lsu_req_*, lsu_we/addr/wdata/wstrb/size - load/store request
//   lsu_rsp_*, lsu_rdata - load/store completion pulse, load data (0 on store), error
//   io_master_aw*/w*/b* - AXI write channels
//   io_master_ar*/r*    - AXI read channels
module axi_arb_bridge #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] IFU_ID = 4'd0,
  parameter logic [3:0] LSU_ID = 4'd1
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic [2:0]          lsu_size,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,

  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [3:0]          io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,

  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,

  input  logic                io_master_bvalid,
  output logic                io_master_bready,
  input  logic [1:0]          io_master_bresp,
  input  logic [3:0]          io_master_bid,

  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [3:0]          io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,

  input  logic                io_master_rvalid,
  output logic                io_master_rready,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic                io_master_rlast,
  input  logic [3:0]          io_master_rid
);

  localparam int STRB_W = DATA_W / 8;
  // Fetches always use the full bus width.
  localparam logic [2:0] FULL_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                last_lsu_q, last_lsu_d;   // 1: LSU won the last grant
  logic                owner_lsu_q, owner_lsu_d; // owner of the in-flight transaction
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          id_q, id_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic                ifu_rsp_err_q, ifu_rsp_err_d;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                lsu_rsp_err_q, lsu_rsp_err_d;

  logic                pick_lsu;
  logic                ifu_grant, lsu_grant;
  logic                aw_fire, w_fire;
  logic                rd_err, wr_err;

  // LSU wins when it is the only requester, or when both request and the
  // IFU was granted last. last_lsu_q resets to 0 so the LSU goes first.
  assign pick_lsu      = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
  assign lsu_req_ready = (state_q == IDLE) && pick_lsu;
  assign ifu_req_ready = (state_q == IDLE) && ifu_req_valid && !pick_lsu;
  assign lsu_grant     = lsu_req_valid && lsu_req_ready;
  assign ifu_grant     = ifu_req_valid && ifu_req_ready;

  // AW and W are offered together; each drops once its own beat is taken.
  assign io_master_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign io_master_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign io_master_wlast   = io_master_wvalid;
  assign io_master_bready  = (state_q == WR_RESP);
  assign io_master_arvalid = (state_q == RD_ADDR);
  assign io_master_rready  = (state_q == RD_DATA);

  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = id_q;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = 2'b01;
  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = id_q;
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = 2'b01;

  assign aw_fire = io_master_awvalid && io_master_awready;
  assign w_fire  = io_master_wvalid && io_master_wready;

  // A bad response still completes the transaction; it only raises the flag.
  assign rd_err = (io_master_rresp != 2'b00) || (io_master_rid != id_q) || !io_master_rlast;
  assign wr_err = (io_master_bresp != 2'b00) || (io_master_bid != id_q);

  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign ifu_rsp_err   = ifu_rsp_err_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign lsu_rsp_err   = lsu_rsp_err_q;

  always_comb begin
    state_d         = state_q;
    last_lsu_d      = last_lsu_q;
    owner_lsu_d     = owner_lsu_q;
    addr_d          = addr_q;
    id_d            = id_q;
    size_d          = size_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    ifu_rsp_err_d   = ifu_rsp_err_q;
    lsu_rsp_valid_d = 1'b0;
    lsu_rdata_d     = lsu_rdata_q;
    lsu_rsp_err_d   = lsu_rsp_err_q;

    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (lsu_grant) begin
          last_lsu_d  = 1'b1;
          owner_lsu_d = 1'b1;
          addr_d      = lsu_addr;
          id_d        = LSU_ID;
          size_d      = lsu_size;
          wdata_d     = lsu_wdata;
          wstrb_d     = lsu_wstrb;
          state_d     = lsu_we ? WR_REQ : RD_ADDR;
        end else if (ifu_grant) begin
          last_lsu_d  = 1'b0;
          owner_lsu_d = 1'b0;
          addr_d      = ifu_addr;
          id_d        = IFU_ID;
          size_d      = FULL_SIZE;
          state_d     = RD_ADDR;
        end
      end

      RD_ADDR: begin
        if (io_master_arready) begin
          state_d = RD_DATA;
        end
      end

      RD_DATA: begin
        if (io_master_rvalid) begin
          if (owner_lsu_q) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rdata_d     = io_master_rdata;
            lsu_rsp_err_d   = rd_err;
          end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rdata_d     = io_master_rdata;
            ifu_rsp_err_d   = rd_err;
          end
          state_d = IDLE;
        end
      end

      WR_REQ: begin
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        if (io_master_bvalid) begin
          lsu_rsp_valid_d = 1'b1;
          lsu_rdata_d     = '0;
          lsu_rsp_err_d   = wr_err;
          state_d         = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_lsu_q      <= 1'b0;
      owner_lsu_q     <= 1'b0;
      addr_q          <= '0;
      id_q            <= '0;
      size_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rdata_q     <= '0;
      ifu_rsp_err_q   <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rdata_q     <= '0;
      lsu_rsp_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_lsu_q      <= last_lsu_d;
      owner_lsu_q     <= owner_lsu_d;
      addr_q          <= addr_d;
      id_q            <= id_d;
      size_q          <= size_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      aw_done_q       <= aw_done_d;
      w_done_q        <= w_done_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rdata_q     <= ifu_rdata_d;
      ifu_rsp_err_q   <= ifu_rsp_err_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rdata_q     <= lsu_rdata_d;
      lsu_rsp_err_q   <= lsu_rsp_err_d;
    end
  end

endmodule

// File: tb/tb_axi_arb_bridge.sv
// tb/tb_axi_arb_bridge.sv - scoreboard bench for axi_arb_bridge
module tb_axi_arb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } axi_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_rsp_valid, ifu_rsp_err;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_we;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [3:0]    lsu_wstrb;
  logic [2:0]    lsu_size;
  logic          lsu_rsp_valid, lsu_rsp_err;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [3:0]    awid, bid, arid, rid;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic          arvalid, arready, rvalid, rready, rlast;

  axi_arb_bridge #(.ADDR_W(AW), .DATA_W(DW), .IFU_ID(4'd0), .LSU_ID(4'd1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_size(lsu_size),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp),
    .io_master_bid(bid),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rdata(rdata),
    .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_aw     = 0;
  int n_w      = 0;

  axi_exp_t axi_q[$];
  rsp_exp_t ifu_q[$];
  rsp_exp_t lsu_q[$];
  int       grant_log[$];   // 0 = IFU, 1 = LSU

  int          cfg_ar_wait = 0, cfg_r_wait = 0, cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  bit          cfg_rid_bad = 0, cfg_bid_bad = 0, cfg_rlast = 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pop_axi(output axi_exp_t e);
    e = '{default: '0};
    if (axi_q.size() == 0) check_eq("axi_unexpected_request", 64'(axi_q.size()), 64'd1);
    else e = axi_q.pop_front();
  endtask

  function automatic bit exp_rd_err();
    return (cfg_rresp != 2'b00) || cfg_rid_bad || !cfg_rlast;
  endfunction

  // ---------------- clients ----------------
  task automatic ifu_fetch(input logic [31:0] a);
    int n;
    n = 0;
    ifu_req_valid = 1'b1;
    ifu_addr      = a;
    #1;
    while (!ifu_req_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!ifu_req_ready) check_eq("ifu_grant_timeout", 64'(ifu_req_ready), 64'd1);
    else begin
      axi_q.push_back('{addr: a, id: 4'd0, size: 3'd2, wdata: 32'h0, wstrb: 4'h0});
      ifu_q.push_back('{data: cfg_rdata, err: exp_rd_err()});
      grant_log.push_back(0);
    end
    @(negedge clk);
    ifu_req_valid = 1'b0;
  endtask

  task automatic lsu_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] strb, input logic [2:0] sz);
    int n;
    n = 0;
    lsu_req_valid = 1'b1;
    lsu_we = we; lsu_addr = a; lsu_wdata = d; lsu_wstrb = strb; lsu_size = sz;
    #1;
    while (!lsu_req_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!lsu_req_ready) check_eq("lsu_grant_timeout", 64'(lsu_req_ready), 64'd1);
    else begin
      axi_q.push_back('{addr: a, id: 4'd1, size: sz, wdata: d, wstrb: strb});
      if (we) lsu_q.push_back('{data: 32'h0, err: (cfg_bresp != 2'b00) || cfg_bid_bad});
      else    lsu_q.push_back('{data: cfg_rdata, err: exp_rd_err()});
      grant_log.push_back(1);
    end
    @(negedge clk);
    lsu_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((ifu_q.size() + lsu_q.size()) != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    check_eq("drain", 64'(ifu_q.size() + lsu_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // ---------------- read slave ----------------
  initial begin : rd_slave
    bit ar_hs, r_hs, rd_pend;
    int ar_cnt, r_cnt;
    logic [3:0] cur_id;
    axi_exp_t e;
    ar_hs = 0; r_hs = 0; rd_pend = 0; ar_cnt = 0; r_cnt = 0; cur_id = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_hs = 0; r_hs = 0; rd_pend = 0; ar_cnt = 0; r_cnt = 0;
        arready = 0; rvalid = 0;
      end else begin
        if (ar_hs) rd_pend = 1;
        if (r_hs) rd_pend = 0;
        ar_hs = 0; r_hs = 0;
        arready = 0; rvalid = 0;
        if (!rd_pend && arvalid) begin
          if (ar_cnt >= cfg_ar_wait) begin
            arready = 1; ar_hs = 1; ar_cnt = 0; cur_id = arid;
            pop_axi(e);
            check_eq("araddr", 64'(araddr), 64'(e.addr));
            check_eq("arid", 64'(arid), 64'(e.id));
            check_eq("arsize", 64'(arsize), 64'(e.size));
            check_eq("arlen_arburst", 64'({arlen, arburst}), 64'({8'd0, 2'b01}));
          end else ar_cnt++;
        end
        if (rd_pend) begin
          if (r_cnt >= cfg_r_wait) begin
            rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; rlast = cfg_rlast;
            rid = cfg_rid_bad ? (cur_id ^ 4'hF) : cur_id;
            r_hs = rready;
            if (r_hs) r_cnt = 0;
          end else r_cnt++;
        end
      end
    end
  end

  // ---------------- write slave ----------------
  initial begin : wr_slave
    bit aw_hs, w_hs, b_hs, aw_d, w_d, have;
    int aw_cnt, w_cnt, b_cnt;
    logic [3:0] cur_id;
    axi_exp_t e;
    aw_hs = 0; w_hs = 0; b_hs = 0; aw_d = 0; w_d = 0; have = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; cur_id = '0; e = '{default: '0};
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_hs = 0; w_hs = 0; b_hs = 0; aw_d = 0; w_d = 0; have = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        awready = 0; wready = 0; bvalid = 0;
      end else begin
        if (aw_hs) aw_d = 1;
        if (w_hs) w_d = 1;
        if (b_hs) begin aw_d = 0; w_d = 0; have = 0; end
        aw_hs = 0; w_hs = 0; b_hs = 0;
        awready = 0; wready = 0; bvalid = 0;
        if (aw_d && awvalid) check_eq("awvalid_after_aw", 64'(awvalid), 64'd0);
        if (w_d && wvalid)   check_eq("wvalid_after_w", 64'(wvalid), 64'd0);
        if (!aw_d && awvalid) begin
          if (aw_cnt >= cfg_aw_wait) begin
            awready = 1; aw_hs = 1; aw_cnt = 0; n_aw++; cur_id = awid;
            if (!have) begin pop_axi(e); have = 1; end
            check_eq("awaddr", 64'(awaddr), 64'(e.addr));
            check_eq("awid", 64'(awid), 64'(e.id));
            check_eq("awsize", 64'(awsize), 64'(e.size));
            check_eq("awlen_awburst", 64'({awlen, awburst}), 64'({8'd0, 2'b01}));
          end else aw_cnt++;
        end
        if (!w_d && wvalid) begin
          if (w_cnt >= cfg_w_wait) begin
            wready = 1; w_hs = 1; w_cnt = 0; n_w++;
            if (!have) begin pop_axi(e); have = 1; end
            check_eq("wdata", 64'(wdata), 64'(e.wdata));
            check_eq("wstrb", 64'(wstrb), 64'(e.wstrb));
            check_eq("wlast", 64'(wlast), 64'd1);
          end else w_cnt++;
        end
        if (aw_d && w_d) begin
          if (b_cnt >= cfg_b_wait) begin
            bvalid = 1; bresp = cfg_bresp;
            bid = cfg_bid_bad ? (cur_id ^ 4'hF) : cur_id;
            b_hs = bready;
            if (b_hs) b_cnt = 0;
          end else b_cnt++;
        end
      end
    end
  end

  // ---------------- response scoreboard ----------------
  initial begin : rsp_mon
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (ifu_rsp_valid) begin
        if (ifu_q.size() == 0) check_eq("ifu_unexpected_rsp", 64'(ifu_rsp_valid), 64'd0);
        else begin
          r = ifu_q.pop_front();
          check_eq("ifu_rdata", 64'(ifu_rdata), 64'(r.data));
          check_eq("ifu_rsp_err", 64'(ifu_rsp_err), 64'(r.err));
        end
      end
      if (lsu_rsp_valid) begin
        if (lsu_q.size() == 0) check_eq("lsu_unexpected_rsp", 64'(lsu_rsp_valid), 64'd0);
        else begin
          r = lsu_q.pop_front();
          check_eq("lsu_rdata", 64'(lsu_rdata), 64'(r.data));
          check_eq("lsu_rsp_err", 64'(lsu_rsp_err), 64'(r.err));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, aw0, w0;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_size = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    check_eq("rst_rsp", 64'({ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err}), 64'd0);
    check_eq("rst_data", 64'(ifu_rdata | lsu_rdata | araddr | wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    ifu_req_valid = 1; lsu_req_valid = 1; #1;
    check_eq("rst_lsu_priority", 64'({ifu_req_ready, lsu_req_ready}), 64'b01);
    ifu_req_valid = 0; lsu_req_valid = 0;
    @(negedge clk);

    // Both clients request continuously: grants alternate starting with LSU
    cfg_rdata = 32'h1111_2222;
    grant_log.delete();
    fork
      begin for (int i = 0; i < 2; i++) lsu_access(1'b0, 32'h2000_0000 + 32'(i*4), 32'h0, 4'h0, 3'd2); end
      begin for (int j = 0; j < 2; j++) ifu_fetch(32'h8000_0100 + 32'(j*4)); end
    join
    wait_drain();
    check_eq("grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check_eq($sformatf("grant_order_%0d", k), 64'(grant_log[k]), 64'((k % 2 == 0) ? 1 : 0));

    // Fetch with zero-wait slave and latency measurement
    cfg_rdata = 32'h0000_0413;
    ifu_fetch(32'h8000_0000);
    lat = 1;
    while (!ifu_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    check_eq("fetch_latency", 64'(lat), 64'd3);
    wait_drain();

    // Store, AW accepted 3 cycles after W
    cfg_w_wait = 0; cfg_aw_wait = 3;
    aw0 = n_aw; w0 = n_w;
    lsu_access(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b0011, 3'd2);
    wait_drain();
    check_eq("store_aw_beats", 64'(n_aw - aw0), 64'd1);
    check_eq("store_w_beats", 64'(n_w - w0), 64'd1);
    cfg_aw_wait = 0;

    // Store with both channels delayed differently and a bad bresp
    cfg_aw_wait = 1; cfg_w_wait = 2; cfg_b_wait = 2; cfg_bresp = 2'b11;
    lsu_access(1'b1, 32'h1000_0020, 32'hCAFE_F00D, 4'b1100, 3'd1);
    wait_drain();
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0; cfg_bresp = 2'b00;

    // Load with SLVERR, then check the FSM is back in IDLE
    cfg_rresp = 2'b10; cfg_rdata = 32'h5555_AAAA; cfg_ar_wait = 2;
    lsu_access(1'b0, 32'h3000_0004, 32'h0, 4'h0, 3'd0);
    wait_drain();
    cfg_rresp = 2'b00; cfg_ar_wait = 0;
    lsu_req_valid = 1; #1;
    check_eq("idle_after_err", 64'(lsu_req_ready), 64'd1);
    lsu_req_valid = 0;
    @(negedge clk);

    // Read with mismatched RID, and a read missing RLAST
    cfg_rid_bad = 1; cfg_rdata = 32'h0BAD_0001;
    ifu_fetch(32'h8000_0040);
    wait_drain();
    cfg_rid_bad = 0; cfg_rlast = 0; cfg_r_wait = 1;
    lsu_access(1'b0, 32'h3000_0008, 32'h0, 4'h0, 3'd2);
    wait_drain();
    cfg_rlast = 1; cfg_r_wait = 0;

    // Reset asserted while in RD_DATA
    cfg_r_wait = 20; cfg_rdata = 32'h7777_0000;
    ifu_fetch(32'h8000_0080);
    @(negedge clk); @(negedge clk);
    check_eq("rd_data_before_rst", 64'(rready), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valids", 64'({rready, arvalid, awvalid, wvalid, bready}), 64'd0);
    check_eq("async_rst_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err}), 64'd0);
    check_eq("async_rst_data", 64'(ifu_rdata | araddr), 64'd0);
    ifu_q.delete(); axi_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cfg_r_wait = 0;
    repeat (4) @(negedge clk);
    cfg_rdata = 32'h0000_0513;
    ifu_fetch(32'h8000_0000);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
